// File: rtl/sbox_share_scheduler.sv
// Shares one external AES S-box between SubBytes (16-byte state) and SubWord (4-byte key word) jobs.
// Each job is issued byte-serially, reassembled, and returned on a valid/ready result port.
module sbox_share_scheduler #(
  parameter int unsigned SBOX_LAT     = 0,
  parameter bit          KEY_PRIORITY = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_data,
  output logic         st_res_valid,
  input  logic         st_res_ready,
  output logic [127:0] st_res_data,
  input  logic         kw_valid,
  output logic         kw_ready,
  input  logic [31:0]  kw_data,
  output logic         kw_res_valid,
  input  logic         kw_res_ready,
  output logic [31:0]  kw_res_data,
  output logic [7:0]   sbox_in,
  input  logic [7:0]   sbox_out,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN_ST, RUN_KW} state_t;

  state_t       state_q, state_d;
  logic         init_q;
  logic         last_st_q;
  logic [127:0] job_q;
  logic [4:0]   cyc_q;
  logic [4:0]   n_bytes;
  logic [4:0]   cap_pos;
  logic         issuing, capturing, cap_last;
  logic         st_elig, kw_elig, key_wins;
  logic         st_acc, kw_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (st_acc)      state_d = RUN_ST;
        else if (kw_acc) state_d = RUN_KW;
      end
      RUN_ST, RUN_KW: begin
        if (cap_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    n_bytes   = (state_q == RUN_ST) ? 5'd16 : 5'd4;
    cap_pos   = cyc_q - 5'(SBOX_LAT);
    issuing   = (state_q != IDLE) && (cyc_q < n_bytes);
    // cap_pos underflows (and so exceeds cyc_q) until SBOX_LAT cycles have elapsed
    capturing = (state_q != IDLE) && (cap_pos <= cyc_q);
    cap_last  = capturing && (cap_pos == n_bytes - 5'd1);
    busy      = (state_q != IDLE);
    sbox_in   = issuing ? job_q[{cyc_q[3:0], 3'b000} +: 8] : '0;
    st_elig   = init_q && (state_q == IDLE) && !st_res_valid;
    kw_elig   = init_q && (state_q == IDLE) && !kw_res_valid;
    key_wins  = KEY_PRIORITY || last_st_q;
    st_ready  = st_elig && !(kw_valid && kw_elig && key_wins);
    kw_ready  = kw_elig && !(st_valid && st_elig && !key_wins);
    st_acc    = st_valid && st_ready;
    kw_acc    = kw_valid && kw_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q       <= 1'b0;
      last_st_q    <= 1'b1;
      job_q        <= '0;
      cyc_q        <= '0;
      st_res_valid <= 1'b0;
      kw_res_valid <= 1'b0;
      st_res_data  <= '0;
      kw_res_data  <= '0;
    end else begin
      init_q <= 1'b1;
      if (st_res_valid && st_res_ready) st_res_valid <= 1'b0;
      if (kw_res_valid && kw_res_ready) kw_res_valid <= 1'b0;

      if (st_acc) begin
        job_q     <= st_data;
        last_st_q <= 1'b1;
      end else if (kw_acc) begin
        job_q     <= {96'b0, kw_data};
        last_st_q <= 1'b0;
      end

      if (state_q == IDLE) cyc_q <= '0;
      else                 cyc_q <= cyc_q + 5'd1;

      if (capturing) begin
        if (state_q == RUN_ST) st_res_data[{cap_pos[3:0], 3'b000} +: 8] <= sbox_out;
        else                   kw_res_data[{cap_pos[1:0], 3'b000} +: 8] <= sbox_out;
      end

      if (cap_last) begin
        if (state_q == RUN_ST) st_res_valid <= 1'b1;
        else                   kw_res_valid <= 1'b1;
      end
    end
  end

endmodule
